// File: rtl/usr_transfer_ctrl.sv
// Command sequencer for a universal shift register: turns TX / RX / CLEAR commands into
// hold / shift / load / clear mode sequences and reads the register's Q back.
module usr_transfer_ctrl #(
  parameter int unsigned N  = 6,
  parameter int unsigned CW = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic         cmd_dir,
  input  logic [N-1:0] cmd_data,
  input  logic         pause,
  input  logic         ser_in,
  output logic         ser_out,
  output logic         ser_out_valid,
  output logic         usr_enable,
  output logic         usr_clear,
  output logic         usr_s0,
  output logic         usr_s1,
  output logic         usr_msb_in,
  output logic         usr_lsb_in,
  output logic [N-1:0] usr_I,
  input  logic [N-1:0] usr_Q,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] rx_data
);

  typedef enum logic [2:0] {StIdle, StLoad, StShift, StClr, StDone} state_e;

  localparam logic [1:0]    OpTx    = 2'b00;
  localparam logic [1:0]    OpRx    = 2'b01;
  localparam logic [1:0]    OpClear = 2'b10;
  localparam logic [CW-1:0] CntLast = CW'(N - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    op_q, op_d;
  logic          dir_q, dir_d;
  logic [N-1:0]  data_q, data_d;
  logic [N-1:0]  rx_data_q, rx_data_d;
  logic          done_q, done_d;

  // State and captured-command registers; reset aborts any command in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      op_q      <= 2'b00;
      dir_q     <= 1'b0;
      data_q    <= '0;
      rx_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      dir_q     <= dir_d;
      data_q    <= data_d;
      rx_data_q <= rx_data_d;
      done_q    <= done_d;
    end
  end

  // Next-state, shift counter, command capture and completion bookkeeping.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    dir_d     = dir_q;
    data_d    = data_q;
    rx_data_d = rx_data_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          op_d   = cmd_op;
          dir_d  = cmd_dir;
          data_d = cmd_data;
          cnt_d  = '0;
          unique case (cmd_op)
            OpTx:    state_d = StLoad;
            OpRx:    state_d = StShift;
            OpClear: state_d = StClr;
            default: state_d = StDone;
          endcase
        end
      end
      StLoad: begin
        state_d = StShift;
        cnt_d   = '0;
      end
      StShift: begin
        if (!pause) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            state_d = StDone;
          end
        end
      end
      StClr: begin
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
        done_d  = 1'b1;
        // Q already holds the fully assembled word once the last shift has landed.
        if (op_q == OpRx) begin
          rx_data_d = usr_Q;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Register control pins and serial outputs decoded from the current state.
  always_comb begin
    usr_enable    = 1'b0;
    usr_clear     = 1'b0;
    usr_s0        = 1'b0;
    usr_s1        = 1'b0;
    usr_msb_in    = 1'b0;
    usr_lsb_in    = 1'b0;
    usr_I         = '0;
    ser_out       = 1'b0;
    ser_out_valid = 1'b0;
    unique case (state_q)
      StLoad: begin
        usr_enable = 1'b1;
        usr_s1     = 1'b1;
        usr_s0     = 1'b1;
        usr_I      = data_q;
      end
      StShift: begin
        if (!pause) begin
          usr_enable = 1'b1;
          usr_s1     = dir_q;
          usr_s0     = !dir_q;
          if (op_q == OpRx) begin
            usr_msb_in = dir_q ? 1'b0 : ser_in;
            usr_lsb_in = dir_q ? ser_in : 1'b0;
          end else begin
            // The bit about to leave the register is presented before the shift edge.
            ser_out       = dir_q ? usr_Q[N-1] : usr_Q[0];
            ser_out_valid = 1'b1;
          end
        end
      end
      StClr: begin
        usr_enable = 1'b1;
        usr_clear  = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign cmd_ready = (state_q == StIdle) && !reset;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign rx_data   = rx_data_q;

endmodule
